// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between the CPU controller (default owner) and a loader/debug port.
// Optional back-to-back loader bursts are enabled by defining MEM_ARB_LOCK_EN (adds the ld_lock input).
module mem_port_arbiter #(
  parameter int AWIDTH    = 5,
  parameter int DWIDTH    = 8,
  parameter int LD_CYCLES = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_wr,
`ifdef MEM_ARB_LOCK_EN
  input  logic              ld_lock,
`endif
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_done,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata
);

  localparam int ACC_W  = (LD_CYCLES > 1) ? $clog2(LD_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [ACC_W-1:0]  ACC_INIT = ACC_W'(LD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_CPU = 2'd0,
    S_LD  = 2'd1,
    S_REL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ACC_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic                lat_wr_q, lat_wr_d;
  logic [AWIDTH-1:0]   lat_addr_q, lat_addr_d;
  logic [DWIDTH-1:0]   lat_wdata_q, lat_wdata_d;
  logic                cpu_busy;
  logic                grant;

`ifdef MEM_ARB_LOCK_EN
  logic [WAIT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                burst_more;
`endif

  assign cpu_busy = cpu_rd | cpu_wr;
  assign grant    = ld_req && (!cpu_busy || (wait_cnt_q == WAIT_MAX));

`ifdef MEM_ARB_LOCK_EN
  assign burst_more = ld_lock && ld_req && (burst_cnt_q < WAIT_MAX);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_CPU;
      wait_cnt_q  <= '0;
      acc_cnt_q   <= '0;
      lat_wr_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
`ifdef MEM_ARB_LOCK_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      lat_wr_q    <= lat_wr_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
`ifdef MEM_ARB_LOCK_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    lat_wr_d    = lat_wr_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
`ifdef MEM_ARB_LOCK_EN
    burst_cnt_d = burst_cnt_q;
`endif
    cpu_stall   = 1'b0;
    ld_gnt      = 1'b0;
    ld_done     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = lat_addr_q;
    mem_wdata   = lat_wdata_q;

    case (state_q)
      S_CPU: begin
        // The CPU access in the deciding cycle is passed through even when the loader wins.
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (grant) begin
          state_d     = S_LD;
          wait_cnt_d  = '0;
          acc_cnt_d   = ACC_INIT;
          lat_wr_d    = ld_wr;
          lat_addr_d  = ld_addr;
          lat_wdata_d = ld_wdata;
`ifdef MEM_ARB_LOCK_EN
          burst_cnt_d = WAIT_W'(1);
`endif
        end else if (ld_req) begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          wait_cnt_d = '0;
        end
      end

      S_LD: begin
        ld_gnt     = 1'b1;
        cpu_stall  = 1'b1;
        mem_wr     = lat_wr_q;
        mem_rd     = !lat_wr_q;
        wait_cnt_d = '0;
        if (acc_cnt_q == '0) begin
          state_d = S_REL;
        end else begin
          acc_cnt_d = acc_cnt_q - ACC_W'(1);
        end
      end

      S_REL: begin
        ld_done    = 1'b1;
        cpu_stall  = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_CPU;
`ifdef MEM_ARB_LOCK_EN
        // A locked burst re-enters S_LD directly, capped so the CPU is never starved.
        if (burst_more) begin
          state_d     = S_LD;
          acc_cnt_d   = ACC_INIT;
          lat_wr_d    = ld_wr;
          lat_addr_d  = ld_addr;
          lat_wdata_d = ld_wdata;
          burst_cnt_d = burst_cnt_q + WAIT_W'(1);
        end
`endif
      end

      default: begin
        state_d = S_CPU;
      end
    endcase
  end

  a_gnt_done_excl: assert property (@(posedge clk) disable iff (rst) !(ld_gnt && ld_done));
  a_ld_strobe_excl: assert property (@(posedge clk) disable iff (rst)
                                     (state_q == S_LD) |-> (mem_rd != mem_wr));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
// Exercises the locked-burst path as well when built with MEM_ARB_LOCK_EN.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_stall;
  logic       ld_req;
  logic       ld_wr;
`ifdef MEM_ARB_LOCK_EN
  logic       ld_lock;
`endif
  logic [4:0] ld_addr;
  logic [7:0] ld_wdata;
  logic       ld_gnt;
  logic       ld_done;
  logic       mem_rd;
  logic       mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;

  int checkCount = 0;
  int failCount  = 0;
  int stallCycles;
  int donePulses;

  mem_port_arbiter #(
    .AWIDTH(5),
    .DWIDTH(8),
    .LD_CYCLES(2),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall),
    .ld_req(ld_req),
    .ld_wr(ld_wr),
`ifdef MEM_ARB_LOCK_EN
    .ld_lock(ld_lock),
`endif
    .ld_addr(ld_addr),
    .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt),
    .ld_done(ld_done),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move n rising edges forward and land 2 time units after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    ld_req    = 1'b0;
    ld_wr     = 1'b0;
    ld_addr   = '0;
    ld_wdata  = '0;
`ifdef MEM_ARB_LOCK_EN
    ld_lock   = 1'b0;
`endif

    // Reset state
    #3;
    checkOutput("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
    checkOutput("rst_ld_done", {31'd0, ld_done}, 32'd0);
    checkOutput("rst_mem_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    applyStimulus(1);
    rst = 1'b0;
    applyStimulus(1);

    // Idle CPU, loader write 0x5A to 0x1F
    $display("[TB] loader write with idle CPU");
    ld_req = 1'b1; ld_wr = 1'b1; ld_addr = 5'h1F; ld_wdata = 8'h5A;
    #1;
    checkOutput("wr_req_cycle_gnt", {31'd0, ld_gnt}, 32'd0);
    applyStimulus(1);
    ld_req = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("wr_ld_gnt", {31'd0, ld_gnt}, 32'd1);
      checkOutput("wr_stall", {31'd0, cpu_stall}, 32'd1);
      checkOutput("wr_strobes", {30'd0, mem_rd, mem_wr}, 32'd1);
      checkOutput("wr_addr", {27'd0, mem_addr}, 32'h1F);
      checkOutput("wr_wdata", {24'd0, mem_wdata}, 32'h5A);
      applyStimulus(1);
      #1;
    end
    checkOutput("wr_done", {31'd0, ld_done}, 32'd1);
    checkOutput("wr_rel_gnt", {31'd0, ld_gnt}, 32'd0);
    checkOutput("wr_rel_stall", {31'd0, cpu_stall}, 32'd1);
    checkOutput("wr_rel_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    applyStimulus(1);
    #1;
    checkOutput("wr_resume_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("wr_resume_done", {31'd0, ld_done}, 32'd0);

    // CPU read held, loader preempts after wait_cnt saturates
    $display("[TB] preemption of continuous CPU reads");
    applyStimulus(1);
    cpu_rd = 1'b1; cpu_addr = 5'h03;
    ld_req = 1'b1; ld_wr = 1'b0; ld_addr = 5'h0A;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("pre_wait_gnt", {31'd0, ld_gnt}, 32'd0);
      checkOutput("pre_cpu_rd_pass", {30'd0, mem_rd, mem_wr}, 32'd2);
      checkOutput("pre_cpu_addr_pass", {27'd0, mem_addr}, 32'h03);
      applyStimulus(1);
      #1;
    end
    checkOutput("pre_gnt", {31'd0, ld_gnt}, 32'd1);
    checkOutput("pre_ld_addr", {27'd0, mem_addr}, 32'h0A);
    stallCycles = 0;
    donePulses  = 0;
    for (int k = 0; k < 4; k++) begin
      if (cpu_stall) stallCycles++;
      if (ld_done) donePulses++;
      if (k < 3) begin
        applyStimulus(1);
        #1;
      end
    end
    checkOutput("pre_stall_len", stallCycles, 32'd3);
    checkOutput("pre_done_pulses", donePulses, 32'd1);
    ld_req = 1'b0; cpu_rd = 1'b0;

    // Loader read, request dropped after one cycle
    $display("[TB] loader read with early request drop");
    applyStimulus(1);
    ld_req = 1'b1; ld_wr = 1'b0; ld_addr = 5'h11;
    applyStimulus(1);
    ld_req = 1'b0; ld_wr = 1'b1; ld_addr = 5'h05;
    #1;
    donePulses = 0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("rd_strobes", {30'd0, mem_rd, mem_wr}, 32'd2);
      checkOutput("rd_addr", {27'd0, mem_addr}, 32'h11);
      checkOutput("rd_gnt", {31'd0, ld_gnt}, 32'd1);
      if (ld_done) donePulses++;
      applyStimulus(1);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      if (ld_done) donePulses++;
      applyStimulus(1);
      #1;
    end
    checkOutput("rd_done_once", donePulses, 32'd1);
    ld_wr = 1'b0;

    // Simultaneous CPU write and loader request with wait_cnt below limit
    $display("[TB] CPU write vs loader request");
    cpu_wr = 1'b1; cpu_addr = 5'h07; cpu_wdata = 8'hC3;
    ld_req = 1'b1; ld_addr = 5'h12;
    #1;
    checkOutput("cw_strobes", {30'd0, mem_rd, mem_wr}, 32'd1);
    checkOutput("cw_addr", {27'd0, mem_addr}, 32'h07);
    checkOutput("cw_wdata", {24'd0, mem_wdata}, 32'hC3);
    checkOutput("cw_gnt", {31'd0, ld_gnt}, 32'd0);
    ld_req = 1'b0;
    applyStimulus(1);
    #1;
    checkOutput("cw_next_gnt", {31'd0, ld_gnt}, 32'd0);
    checkOutput("cw_next_stall", {31'd0, cpu_stall}, 32'd0);

    // Illegal dual strobe is passed through unchanged
    cpu_rd = 1'b1;
    #1;
    checkOutput("dual_strobes", {30'd0, mem_rd, mem_wr}, 32'd3);
    applyStimulus(1);
    cpu_rd = 1'b0; cpu_wr = 1'b0;

    // Reset during the second loader cycle
    $display("[TB] reset mid loader access");
    ld_req = 1'b1; ld_wr = 1'b1; ld_addr = 5'h14; ld_wdata = 8'h99;
    applyStimulus(2);
    #1;
    checkOutput("mid_gnt_before_rst", {31'd0, ld_gnt}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_gnt", {31'd0, ld_gnt}, 32'd0);
    checkOutput("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("mid_rst_done", {31'd0, ld_done}, 32'd0);
    applyStimulus(2);
    ld_req = 1'b0;
    rst = 1'b0;
    donePulses = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      #1;
      if (ld_done) donePulses++;
    end
    checkOutput("mid_no_done", donePulses, 32'd0);
    cpu_rd = 1'b1; cpu_addr = 5'h09;
    #1;
    checkOutput("mid_post_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("mid_post_mirror", {27'd0, mem_addr}, 32'h09);
    checkOutput("mid_post_strobes", {30'd0, mem_rd, mem_wr}, 32'd2);
    cpu_rd = 1'b0;

    // Held request: locked burst of MAX_WAIT accesses, or a single access without the lock feature
    $display("[TB] held loader request");
    applyStimulus(1);
    ld_req = 1'b1; ld_wr = 1'b1; ld_addr = 5'h02; ld_wdata = 8'h3C;
`ifdef MEM_ARB_LOCK_EN
    ld_lock = 1'b1;
`endif
    applyStimulus(1);
    #1;
    stallCycles = 0;
    donePulses  = 0;
`ifdef MEM_ARB_LOCK_EN
    for (int k = 0; k < 12; k++) begin
      if (cpu_stall) stallCycles++;
      if (ld_done) donePulses++;
      applyStimulus(1);
      #1;
    end
    checkOutput("lock_stall_len", stallCycles, 32'd12);
    checkOutput("lock_done_pulses", donePulses, 32'd4);
`else
    for (int k = 0; k < 3; k++) begin
      if (cpu_stall) stallCycles++;
      if (ld_done) donePulses++;
      applyStimulus(1);
      #1;
    end
    checkOutput("held_stall_len", stallCycles, 32'd3);
    checkOutput("held_done_pulses", donePulses, 32'd1);
`endif
    checkOutput("held_cpu_window_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("held_cpu_window_gnt", {31'd0, ld_gnt}, 32'd0);
    ld_req = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    ld_lock = 1'b0;
`endif
    applyStimulus(2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
